axi_sram_slave: RTL
===================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter C_AXI_ID_WIDTH, default 4, ID width of all channels.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter C_AXI_DATA_WIDTH, default 32, data width; STRB_WIDTH = C_AXI_DATA_WIDTH/8 and ADDR_LSB = log2(STRB_WIDTH).
REQ-004 SHALL have parameter MEM_DEPTH_WORDS, default 1024, number of data-width words of storage.
REQ-005 SHALL have ports: clk in 1, the single clock; rst_n in 1, reset, asynchronous and active-low.
REQ-006 SHALL have AW ports: s_axi_awid/awaddr/awlen(8)/awsize(3)/awburst(2)/awvalid in; s_axi_awready out.
REQ-007 SHALL have W ports: s_axi_wdata/wstrb/wlast/wvalid in; s_axi_wready out.
REQ-008 SHALL have B ports: s_axi_bid out ID width; s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-009 SHALL have AR ports: s_axi_arid/araddr/arlen(8)/arsize(3)/arburst(2)/arvalid in; s_axi_arready out.
REQ-010 SHALL have R ports: s_axi_rid, s_axi_rdata, s_axi_rresp(2), s_axi_rlast, s_axi_rvalid out; s_axi_rready in.

Function
REQ-011 SHALL run independent write FSM (W_IDLE, W_DATA, W_RESP) and read FSM (R_IDLE, R_DATA); one outstanding burst per direction.
REQ-012 W_IDLE: awready=1; on awvalid&awready latch id, word index = awaddr>>ADDR_LSB (low bits ignored), awlen, awburst, awsize; go W_DATA; awready=0.
REQ-013 W_DATA: wready=1; each wvalid&wready beat writes byte lanes with wstrb=1 into current word; untouched lanes keep old value.
REQ-014 Address step: INCR (01) +1 word per beat; FIXED (00) no step; no 4KB check.
REQ-015 Beat counter governs burst end: after awlen+1 beats wready=0, go W_RESP; wlast mismatch (asserted early or missing on final beat) sets error flag only.
REQ-016 W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if error flag else 2'b00; hold stable until bready; then W_IDLE, awready=1 next cycle.
REQ-017 Error flag SHALL be set by: burst WRAP/reserved (1x), size > ADDR_LSB, or any beat index >= MEM_DEPTH_WORDS; such beats SHALL NOT modify memory; burst still fully consumed.
REQ-018 R_IDLE: arready=1; on handshake latch AR fields, go R_DATA; rvalid=1 with beat-0 data the cycle after the handshake.
REQ-019 R_DATA: rdata/rresp/rlast/rid stable while rvalid&!rready; each handshake loads next beat next cycle (no bubble); rlast=1 on beat arlen.
REQ-020 Read beat with error condition (REQ-017 criteria) SHALL return rdata=0, rresp=2'b10; other beats 2'b00.
REQ-021 After final R handshake: rvalid=0, go R_IDLE, arready=1 next cycle.
REQ-022 Same-cycle read-beat load and write to same word SHALL return old data (read-before-write).
REQ-023 rid SHALL equal latched arid on all beats.

Reset
REQ-024 On rst_n=0, immediately: both FSMs idle state; awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0; error flags and counters cleared.
REQ-025 awready and arready SHALL assert on first clk edge after rst_n deasserts.
REQ-026 Memory contents SHALL NOT be reset; reset mid-burst abandons the burst with no response.

Verification
REQ-027 AW addr 0x10 len 0, W 0xDEADBEEF strb 0xF -> bresp 00; AR 0x10 len 0 -> rdata 0xDEADBEEF, rlast=1, rresp 00.
REQ-028 INCR write 0x100 len 3 data 1,2,3,4, beat 2 strb 0x3 over prior 0xAAAAAAAA -> read back 1,2,0xAAAA0003,4.
REQ-029 FIXED write 0x40 len 2 data 5,6,7 -> word 0x40 = 7; INCR read len 1 at 0x40 -> 7 then word 0x44.
REQ-030 Write at word 1023 len 1 (MEM_DEPTH 1024) -> word 1023 updated, bresp 10; read same -> beat1 rdata 0, rresp 10.
REQ-031 Read len 3 with rready low 5 cycles between beats -> rdata stable, correct order, rlast only on beat 3; wlast early on beat 1 of len 2 write -> bresp 10, three beats accepted.
REQ-032 rst_n low during W_DATA beat 2 -> all valids/readies 0 immediately, no B; awready=1 first edge after release.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI4 slave backed by a word-addressed on-chip SRAM. Independent write
//   (AW/W/B) and read (AR/R) engines, one outstanding burst per direction.
//   Supports FIXED and INCR bursts. WRAP/reserved bursts, oversize beats and
//   beats beyond the end of storage are consumed but flagged with SLVERR and
//   never touch memory (reads of such beats return zero).
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   s_axi_aw*             write address channel (awready registered)
//   s_axi_w*              write data channel (wready registered)
//   s_axi_b*              write response channel (registered)
//   s_axi_ar*             read address channel (arready registered)
//   s_axi_r*              read data channel (registered, no bubbles)
module axi_sram_slave #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH_WORDS  = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // AW
    input  logic [C_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    // W
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    // B
    output logic [C_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    // AR
    input  logic [C_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    // R
    output logic [C_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [C_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int STRB_WIDTH = C_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int MEM_AW     = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam int IW         = C_AXI_ADDR_WIDTH;

    localparam logic [IW-1:0] DEPTH_IDX   = IW'(MEM_DEPTH_WORDS);
    localparam logic [2:0]    SIZE_MAX    = 3'(ADDR_LSB);
    localparam logic [1:0]    BURST_INCR  = 2'b01;
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    // A beat is unusable if the burst type is WRAP/reserved, the transfer is
    // wider than the bus, or the word lies outside the storage.
    function automatic logic beat_bad(input logic [1:0]    burst,
                                      input logic [2:0]    size,
                                      input logic [IW-1:0] idx);
        return burst[1] || (size > SIZE_MAX) || (idx >= DEPTH_IDX);
    endfunction

    logic [C_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

    // ---------------- write engine state ----------------
    wstate_e                     wstate_q, wstate_d;
    logic                        awready_q, awready_d;
    logic                        wready_q, wready_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic [C_AXI_ID_WIDTH-1:0]   bid_q, bid_d;
    logic [C_AXI_ID_WIDTH-1:0]   wid_q, wid_d;
    logic [IW-1:0]               widx_q, widx_d;
    logic [7:0]                  wlen_q, wlen_d;
    logic [7:0]                  wcnt_q, wcnt_d;
    logic [1:0]                  wburst_q, wburst_d;
    logic [2:0]                  wsize_q, wsize_d;
    logic                        werr_q, werr_d;

    logic                        mem_we;
    logic [MEM_AW-1:0]           mem_widx;
    logic                        w_last_beat;
    logic                        w_bad;

    // ---------------- read engine state ----------------
    rstate_e                     rstate_q, rstate_d;
    logic                        arready_q, arready_d;
    logic                        rvalid_q, rvalid_d;
    logic                        rlast_q, rlast_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [C_AXI_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IW-1:0]               ridx_q, ridx_d;
    logic [7:0]                  rlen_q, rlen_d;
    logic [7:0]                  rcnt_q, rcnt_d;
    logic [1:0]                  rburst_q, rburst_d;
    logic [2:0]                  rsize_q, rsize_d;

    logic                        ld_en;
    logic [IW-1:0]               ld_idx;
    logic [1:0]                  ld_burst;
    logic [2:0]                  ld_size;
    logic                        ld_bad;

    // ---------------- write engine ----------------
    always_comb begin
        wstate_d    = wstate_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        wid_d       = wid_q;
        widx_d      = widx_q;
        wlen_d      = wlen_q;
        wcnt_d      = wcnt_q;
        wburst_d    = wburst_q;
        wsize_d     = wsize_q;
        werr_d      = werr_q;
        mem_we      = 1'b0;
        mem_widx    = widx_q[MEM_AW-1:0];
        w_last_beat = (wcnt_q == wlen_q);
        w_bad       = beat_bad(wburst_q, wsize_q, widx_q);

        unique case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (s_axi_awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = W_DATA;
                    wid_d     = s_axi_awid;
                    widx_d    = s_axi_awaddr >> ADDR_LSB;
                    wlen_d    = s_axi_awlen;
                    wburst_d  = s_axi_awburst;
                    wsize_d   = s_axi_awsize;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && wready_q) begin
                    mem_we = !w_bad;
                    // The beat counter, not wlast, ends the burst; a wlast
                    // disagreement is only reported.
                    werr_d = werr_q | w_bad | (s_axi_wlast != w_last_beat);
                    wcnt_d = wcnt_q + 8'd1;
                    if (wburst_q == BURST_INCR) begin
                        widx_d = widx_q + IW'(1);
                    end
                    if (w_last_beat) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = wid_q;
                        bresp_d  = werr_d ? RESP_SLVERR : RESP_OKAY;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // ---------------- read engine ----------------
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rburst_d  = rburst_q;
        rsize_d   = rsize_q;
        ld_en     = 1'b0;
        ld_idx    = ridx_q;
        ld_burst  = rburst_q;
        ld_size   = rsize_q;

        unique case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rstate_d  = R_DATA;
                    rid_d     = s_axi_arid;
                    ridx_d    = s_axi_araddr >> ADDR_LSB;
                    rlen_d    = s_axi_arlen;
                    rburst_d  = s_axi_arburst;
                    rsize_d   = s_axi_arsize;
                    rcnt_d    = '0;
                    rlast_d   = (s_axi_arlen == 8'd0);
                    ld_en     = 1'b1;
                    ld_idx    = ridx_d;
                    ld_burst  = s_axi_arburst;
                    ld_size   = s_axi_arsize;
                end
            end
            R_DATA: begin
                if (rvalid_q && s_axi_rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        // Next beat is fetched on the handshake so rvalid
                        // never drops inside a burst.
                        if (rburst_q == BURST_INCR) begin
                            ridx_d = ridx_q + IW'(1);
                        end
                        rcnt_d  = rcnt_q + 8'd1;
                        rlast_d = (rcnt_d == rlen_q);
                        ld_en   = 1'b1;
                        ld_idx  = ridx_d;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase

        // Memory is sampled combinationally before this edge's write lands,
        // so a same-cycle read of a word being written returns the old data.
        ld_bad = beat_bad(ld_burst, ld_size, ld_idx);
        if (ld_en) begin
            rdata_d = ld_bad ? '0 : mem[ld_idx[MEM_AW-1:0]];
            rresp_d = ld_bad ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem[mem_widx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
            wid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wburst_q  <= '0;
            wsize_q   <= '0;
            werr_q    <= 1'b0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rburst_q  <= '0;
            rsize_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            wid_q     <= wid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wburst_q  <= wburst_d;
            wsize_q   <= wsize_d;
            werr_q    <= werr_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rburst_q  <= rburst_d;
            rsize_q   <= rsize_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;

endmodule
